// File: rtl/ov7670_capture_if.sv
// Camera DVP inputs and frame-buffer write port of ov7670_capture.
// The stats signals exist only when CAPTURE_STATS_EN is defined.
interface ov7670_capture_if #(
  parameter int unsigned ADDR_W = 20
`ifdef CAPTURE_STATS_EN
  , parameter int unsigned LINE_W = 10
`endif
);
  logic              cam_vsync;
  logic              cam_href;
  logic [7:0]        cam_data;
  logic              w_clk;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [11:0]       w_data;
  logic              frame_done;
  logic              overflow;
`ifdef CAPTURE_STATS_EN
  logic [LINE_W-1:0] line_count;
  logic [15:0]       frame_count;

  modport slave (
    input  cam_vsync, cam_href, cam_data,
    output w_clk, w_en, w_addr, w_data, frame_done, overflow, line_count, frame_count
  );
  modport master (
    output cam_vsync, cam_href, cam_data,
    input  w_clk, w_en, w_addr, w_data, frame_done, overflow, line_count, frame_count
  );
`else
  modport slave (
    input  cam_vsync, cam_href, cam_data,
    output w_clk, w_en, w_addr, w_data, frame_done, overflow
  );
  modport master (
    output cam_vsync, cam_href, cam_data,
    input  w_clk, w_en, w_addr, w_data, frame_done, overflow
  );
`endif
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 DVP capture: pairs bytes into 12-bit pixels and writes them linearly to the frame buffer.
// Optional per-frame line/frame counters are enabled with the CAPTURE_STATS_EN macro.
module ov7670_capture #(
  parameter int unsigned RESOLUTION_WIDTH  = 640,
  parameter int unsigned RESOLUTION_HEIGHT = 480,
  parameter int unsigned SKIP_FRAMES       = 2
) (
  input logic             pclk,
  input logic             rst,
  ov7670_capture_if.slave bus
);
  localparam int unsigned NPIX   = RESOLUTION_WIDTH * RESOLUTION_HEIGHT;
  localparam int unsigned ADDR_W = $clog2(NPIX) + 1;
  localparam int unsigned SKIP_W = $clog2(SKIP_FRAMES + 1) + 1;

  typedef enum logic [1:0] {WAIT_VS, SKIP, CAPTURE} state_e;

  state_e            state_q;
  logic              vs_q, vs_d_q, href_q;
  logic [7:0]        data_q;
  logic [SKIP_W-1:0] skip_cnt_q;
  logic              phase_q;
  logic [3:0]        red_q;
  logic [ADDR_W-1:0] next_addr_q;
  logic              w_en_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic [11:0]       w_data_q;
  logic              frame_done_q;
  logic              overflow_q;

  logic vs_fall_c, vs_rise_c, skip_more_c;
  assign vs_fall_c   = vs_d_q & ~vs_q;
  assign vs_rise_c   = ~vs_d_q & vs_q;
  // Skip counter saturates at SKIP_FRAMES, so "not yet equal" means "still skipping".
  assign skip_more_c = (SKIP_FRAMES != 0) && (skip_cnt_q != SKIP_W'(SKIP_FRAMES));

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_VS;
      vs_q         <= 1'b0;
      vs_d_q       <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= '0;
      skip_cnt_q   <= '0;
      phase_q      <= 1'b0;
      red_q        <= '0;
      next_addr_q  <= '0;
      w_en_q       <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      vs_q         <= bus.cam_vsync;
      vs_d_q       <= vs_q;
      href_q       <= bus.cam_href;
      data_q       <= bus.cam_data;
      w_en_q       <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        WAIT_VS: begin
          phase_q <= 1'b0;
          if (vs_fall_c) begin
            next_addr_q <= '0;
            w_addr_q    <= '0;
            state_q     <= skip_more_c ? SKIP : CAPTURE;
          end
        end
        SKIP: begin
          if (vs_rise_c) begin
            if (skip_more_c) skip_cnt_q <= skip_cnt_q + SKIP_W'(1);
            state_q <= WAIT_VS;
          end
        end
        CAPTURE: begin
          // End of frame wins over a pending half pixel.
          if (vs_rise_c) begin
            frame_done_q <= 1'b1;
            phase_q      <= 1'b0;
            state_q      <= WAIT_VS;
          end else if (!href_q) begin
            phase_q <= 1'b0;
          end else if (!phase_q) begin
            red_q   <= data_q[3:0];
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            if (next_addr_q == ADDR_W'(NPIX)) begin
              overflow_q <= 1'b1;
            end else begin
              w_en_q      <= 1'b1;
              w_addr_q    <= next_addr_q;
              w_data_q    <= {red_q, data_q};
              next_addr_q <= next_addr_q + ADDR_W'(1);
            end
          end
        end
        default: state_q <= WAIT_VS;
      endcase
    end
  end

  assign bus.w_clk      = pclk;
  assign bus.w_en       = w_en_q;
  assign bus.w_addr     = w_addr_q;
  assign bus.w_data     = w_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;

`ifdef CAPTURE_STATS_EN
  localparam int unsigned LINE_W = $clog2(RESOLUTION_HEIGHT) + 1;

  logic              href_d_q;
  logic [LINE_W-1:0] lines_q;
  logic [LINE_W-1:0] line_count_q;
  logic [15:0]       frame_count_q;
  logic              href_fall_c;
  assign href_fall_c = href_d_q & ~href_q;

  // Lines are counted only while capturing and published together with frame_done.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      href_d_q      <= 1'b0;
      lines_q       <= '0;
      line_count_q  <= '0;
      frame_count_q <= '0;
    end else begin
      href_d_q <= href_q;
      if (state_q == CAPTURE) begin
        if (vs_rise_c) begin
          line_count_q  <= lines_q + LINE_W'(href_fall_c);
          lines_q       <= '0;
          frame_count_q <= frame_count_q + 16'd1;
        end else if (href_fall_c) begin
          lines_q <= lines_q + LINE_W'(1);
        end
      end else begin
        lines_q <= '0;
      end
    end
  end

  assign bus.line_count  = line_count_q;
  assign bus.frame_count = frame_count_q;
`endif
endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Camera-side writer for the video buffer: samples OV7670 8-bit DVP bus (RGB444, two bytes per pixel), assembles 12-bit pixels, writes them linearly into the frame buffer.
- The VGA scan-out controller reads the same buffer on its own port.
- Runs on camera pclk; frame-synchronised to cam_vsync; discards first SKIP_FRAMES frames after reset while camera settles.

Parameters:
- RESOLUTION_WIDTH, 640, active pixels per line.
- RESOLUTION_HEIGHT, 480, active lines per frame.
- SKIP_FRAMES, 2, complete frames discarded after reset before first write (0 = capture first full frame).

Ports:
- pclk  input  1  camera pixel clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cam_vsync  input  1  OV7670 VSYNC, high during vertical blanking.
- cam_href  input  1  OV7670 HREF, high while line bytes are valid.
- cam_data  input  8  OV7670 D[7:0].
- w_clk  output  1  buffer write clock, equal to pclk.
- w_en  output  1  one-cycle write strobe per pixel.
- w_addr  output  $clog2(RESOLUTION_WIDTH*RESOLUTION_HEIGHT)+1  linear pixel address, y*RESOLUTION_WIDTH+x.
- w_data  output  12  {R[3:0],G[3:0],B[3:0]}.
- frame_done  output  1  one-cycle pulse at end of each captured frame.
- overflow  output  1  sticky; set when write would exceed last address.

Behaviour:
- Input stage: cam_vsync, cam_href, cam_data registered once (vs_q, href_q, data_q); vs_q delayed again for edge detection. All decisions use registered copies.
- Reset values: w_en=0, w_addr=0, w_data=0, frame_done=0, overflow=0, state=WAIT_VS, skip counter=0, byte phase=0.
- States:
  - WAIT_VS: wait for vs_q falling edge, then SKIP if skip counter < SKIP_FRAMES, else CAPTURE.
  - SKIP: ignore bytes; on vs_q rising edge increment skip counter and return to WAIT_VS.
  - CAPTURE: assemble and write; on vs_q rising edge pulse frame_done, go to WAIT_VS. Skip counter saturates at SKIP_FRAMES.
- Byte assembly, CAPTURE only:
  - With href_q=1, phase 0 latches data_q[3:0] as R.
  - Phase 1 forms w_data={R,data_q[7:4],data_q[3:0]}, asserts w_en for one cycle, toggles phase.
  - Latency: w_en/w_data/w_addr valid on the edge after the second byte is registered, i.e. 2 pclk after the byte appears on cam_data.
- Address: w_addr holds the address of the current write; post-increments after each w_en. Reset to 0 on every vs_q falling edge.
- Phase resets to 0 on href_q falling edge. An odd trailing byte is dropped, no write.
- Overflow: write with w_addr = W*H-1 is the last accepted one. Further pixels that frame: w_en suppressed, overflow set. overflow clears only on rst.
- frame_done: asserted 1 cycle after the vs_q rising edge is detected in CAPTURE; never asserted in SKIP/WAIT_VS.
- Reset mid-frame: everything returns to reset values immediately. Next write occurs only after a fresh vs_q falling edge plus SKIP_FRAMES skipped frames.
- vs_q rising edge while href_q=1: treated as end of frame; pending half pixel discarded.
- w_clk = pclk combinationally.

Optional Feature:
- Macro CAPTURE_STATS_EN.
- Defined: adds outputs line_count (clog2(H)+1 bits) and frame_count (16 bits).
  - line_count: href_q falling edges in the last captured frame, latched at frame_done.
  - frame_count: increments at each frame_done, wraps at 65535->0.
  - Both reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- W=4,H=2,SKIP=0: one frame, 2 lines of 8 bytes, byte pairs 0x0A,0xBC -> 8 writes, addresses 0..7, w_data=0xABC, single frame_done after vsync rises.
- SKIP=2: three frames of 4x2 -> no w_en in first two frames; writes 0..7 and one frame_done only in third.
- Line of 9 bytes at W=4 -> 4 writes; 9th byte dropped; next line starts at phase 0 with address 4.
- Frame with 3 lines at H=2 -> writes stop after address 7, overflow=1, stays 1 through next frame until rst.
- rst pulsed mid-line after 3 writes -> outputs 0 immediately; next frame restarts at address 0 after SKIP frames.
- CAPTURE_STATS_EN, 2 frames of 4x2 -> line_count=2, frame_count=1 then 2.
